// File: rtl/onehot_dispatch_decoder_pkg.sv
// Shared definitions for the one-hot dispatch decoder: default widths,
// the dispatch FSM state type and the index-to-one-hot decode helper.
package onehot_pkg;

  localparam int IDX_W_DEF = 3;
  localparam int OUT_W_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  // Decode a binary channel index into a one-hot channel select word.
  function automatic logic [OUT_W_DEF-1:0] idx_to_onehot(input logic [IDX_W_DEF-1:0] idx);
    logic [OUT_W_DEF-1:0] oh;
    oh      = {OUT_W_DEF{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/onehot_dispatch_decoder_code_fifo.sv
// Small synchronous FIFO holding pending request indices. Storage is
// registered; the head entry is presented combinationally from storage.
// A push into a full FIFO is refused even if a pop happens on the same edge.
module code_fifo
  import onehot_pkg::*;
#(
  parameter int W     = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == CNT_W'(DEPTH));
  assign empty     = (r_level == CNT_W'(0));
  assign level     = r_level;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping; reset and flush empty the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_level  <= CNT_W'(0);
    end else if (clr) begin
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_level  <= CNT_W'(0);
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + CNT_W'(1);
        2'b01:   r_level <= r_level - CNT_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Entry storage; written only on an accepted push outside reset/flush.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/onehot_dispatch_decoder.sv
// One-hot dispatch decoder: buffers binary channel indices and replays each
// one as a registered one-hot word, held for at least HOLD cycles and until
// the downstream acknowledges. Consecutive words go out back-to-back.
module onehot_dispatch_decoder
  import onehot_pkg::*;
#(
  parameter  int IDX_W = 3,
  parameter  int DEPTH = 4,
  parameter  int HOLD  = 2,
  localparam int OUT_W = 1 << IDX_W,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [IDX_W-1:0] code_in,
  input  logic             code_valid,
  output logic             code_ready,
  output logic [OUT_W-1:0] y,
  output logic             v,
  input  logic             y_ready,
  output logic [CNT_W-1:0] level
);

  localparam int HOLD_W = $clog2(HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD);

  state_t             r_state;
  logic [OUT_W-1:0]   r_y;
  logic               r_v;
  logic [HOLD_W-1:0]  r_hold;

  state_t             w_nxt_state;
  logic [OUT_W-1:0]   w_nxt_y;
  logic               w_nxt_v;
  logic [HOLD_W-1:0]  w_nxt_hold;
  logic               w_pop;
  logic               w_push;
  logic               w_release;
  logic [IDX_W-1:0]   w_head;
  logic [OUT_W-1:0]   w_head_oh;
  logic               w_full;
  logic               w_empty;
  logic [CNT_W-1:0]   w_level;

  assign code_ready = !w_full;
  assign w_push     = code_valid && !w_full;
  assign y          = r_y;
  assign v          = r_v;
  assign level      = w_level;

  code_fifo #(
    .W     (IDX_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (code_in),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  generate
    if (IDX_W == IDX_W_DEF) begin : g_pkg_decode
      assign w_head_oh = idx_to_onehot(w_head);
    end else begin : g_shift_decode
      assign w_head_oh = OUT_W'(1) << w_head;
    end
  endgenerate

  // Next-state, pop request and next output word for the dispatch FSM.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_y     = r_y;
    w_nxt_v     = r_v;
    w_nxt_hold  = r_hold;
    w_pop       = 1'b0;
    w_release   = y_ready && (r_hold >= HOLD_MAX);
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_y     = w_head_oh;
          w_nxt_v     = 1'b1;
          w_nxt_hold  = HOLD_W'(1);
          w_nxt_state = ST_DRIVE;
        end else begin
          w_nxt_y     = {OUT_W{1'b0}};
          w_nxt_v     = 1'b0;
          w_nxt_hold  = HOLD_W'(0);
        end
      end
      ST_DRIVE: begin
        if (w_release) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_nxt_y     = w_head_oh;
            w_nxt_v     = 1'b1;
            w_nxt_hold  = HOLD_W'(1);
          end else begin
            w_nxt_y     = {OUT_W{1'b0}};
            w_nxt_v     = 1'b0;
            w_nxt_hold  = HOLD_W'(0);
            w_nxt_state = ST_IDLE;
          end
        end else if (r_hold < HOLD_MAX) begin
          w_nxt_hold = r_hold + HOLD_W'(1);
        end else begin
          w_nxt_hold = r_hold;
        end
      end
      default: begin
        w_nxt_y     = {OUT_W{1'b0}};
        w_nxt_v     = 1'b0;
        w_nxt_hold  = HOLD_W'(0);
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // FSM state and output registers; reset dominates flush, flush dominates updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_y     <= {OUT_W{1'b0}};
      r_v     <= 1'b0;
      r_hold  <= HOLD_W'(0);
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_y     <= {OUT_W{1'b0}};
      r_v     <= 1'b0;
      r_hold  <= HOLD_W'(0);
    end else begin
      r_state <= w_nxt_state;
      r_y     <= w_nxt_y;
      r_v     <= w_nxt_v;
      r_hold  <= w_nxt_hold;
    end
  end

endmodule
